// File: rtl/prefetch_ar_arbiter.sv
// Arbitrates demand and prefetch AR requests onto one registered AXI AR slice.
// Optional starvation guard enabled by defining PR_AR_ARB_STARVE_GUARD_EN.
module prefetch_ar_arbiter #(
  parameter int unsigned ADDR_BITS       = 64,
  parameter int unsigned BURST_LEN_WIDTH = 8,
  parameter int unsigned TID_WIDTH       = 8,
  parameter int unsigned THROTTLE_WIDTH  = 6,
  parameter int unsigned STARVE_WIDTH    = 4
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       d_ar_valid,
  output logic                       d_ar_ready,
  input  logic [ADDR_BITS-1:0]       d_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] d_ar_len,
  input  logic [TID_WIDTH-1:0]       d_ar_id,
  input  logic                       p_ar_valid,
  output logic                       p_ar_ready,
  input  logic [ADDR_BITS-1:0]       p_ar_addr,
  input  logic [BURST_LEN_WIDTH-1:0] p_ar_len,
  input  logic [TID_WIDTH-1:0]       p_ar_id,
  output logic                       m_ar_valid,
  input  logic                       m_ar_ready,
  output logic [ADDR_BITS-1:0]       m_ar_addr,
  output logic [BURST_LEN_WIDTH-1:0] m_ar_len,
  output logic [TID_WIDTH-1:0]       m_ar_id,
  output logic                       m_ar_is_pr,
  input  logic [THROTTLE_WIDTH-1:0]  crs_prBandwidthThrottle,
  input  logic [STARVE_WIDTH-1:0]    crs_starveLimit
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      slot_free, pr_ok, force_pr, gnt_d, gnt_p;
  logic [THROTTLE_WIDTH-1:0] thr_cnt;

  assign pr_ok = p_ar_valid & en & ~flush & (thr_cnt == '0);

`ifdef PR_AR_ARB_STARVE_GUARD_EN
  logic [STARVE_WIDTH-1:0] starve_cnt;

  assign force_pr = (crs_starveLimit != '0) & (starve_cnt >= crs_starveLimit) & pr_ok;

  // Counts demand wins that overtook an eligible prefetch; saturates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      starve_cnt <= '0;
    end else if (gnt_p) begin
      starve_cnt <= '0;
    end else if (gnt_d && pr_ok && (starve_cnt != '1)) begin
      starve_cnt <= starve_cnt + STARVE_WIDTH'(1);
    end
  end
`else
  logic unused_starve_limit;

  assign unused_starve_limit = ^crs_starveLimit;
  assign force_pr            = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= EMPTY;
    else         state_q <= state_d;
  end

  // Grant and slice occupancy; a draining beat frees the slot in the same cycle.
  always_comb begin
    state_d   = state_q;
    slot_free = 1'b0;
    gnt_d     = 1'b0;
    gnt_p     = 1'b0;
    case (state_q)
      EMPTY:   slot_free = 1'b1;
      HOLD:    slot_free = m_ar_ready;
      default: slot_free = 1'b0;
    endcase
    if (slot_free) begin
      gnt_d   = d_ar_valid & ~force_pr;
      gnt_p   = pr_ok & ~gnt_d;
      state_d = (gnt_d | gnt_p) ? HOLD : EMPTY;
    end
  end

  assign d_ar_ready = gnt_d;
  assign p_ar_ready = gnt_p;
  assign m_ar_valid = (state_q == HOLD);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_ar_addr  <= '0;
      m_ar_len   <= '0;
      m_ar_id    <= '0;
      m_ar_is_pr <= 1'b0;
    end else if (gnt_d) begin
      m_ar_addr  <= d_ar_addr;
      m_ar_len   <= d_ar_len;
      m_ar_id    <= d_ar_id;
      m_ar_is_pr <= 1'b0;
    end else if (gnt_p) begin
      m_ar_addr  <= p_ar_addr;
      m_ar_len   <= p_ar_len;
      m_ar_id    <= p_ar_id;
      m_ar_is_pr <= 1'b1;
    end
  end

  // Prefetch spacing: flush wins over a reload.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      thr_cnt <= '0;
    end else if (flush) begin
      thr_cnt <= '0;
    end else if (gnt_p) begin
      thr_cnt <= crs_prBandwidthThrottle;
    end else if (thr_cnt != '0) begin
      thr_cnt <= thr_cnt - THROTTLE_WIDTH'(1);
    end
  end

endmodule
